// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller driving a word-indexed, combinationally-read data memory.
// Sub-word stores use read-modify-write; sub-word loads are sign/zero-extended.
module lsu_dmem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_word_q, wr_word_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;

  logic        req_mis;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        addr_hi_unused;

  // Upper byte-address bits alias onto the same words.
  assign addr_hi_unused = ^lsu_addr[31:ADDR_W+2];

  assign req_mis = (lsu_size == 2'b11)
                 | ((lsu_size == 2'b01) & lsu_addr[0])
                 | ((lsu_size == 2'b10) & (lsu_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0;
      mis_q     <= 1'b0;
      rdata_q   <= 32'h0;
      addr_q    <= 32'h0;
      wr_word_q <= 32'h0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wr_word_q <= wr_word_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          if (req_mis)                           state_d = S_DONE;
          else if (!lsu_we || lsu_size != 2'b10) state_d = S_READ;
          else                                   state_d = S_WRITE;
        end
      end
      S_READ:  state_d = we_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from live read data.
  always_comb begin
    rd_shift = DMEM_data_out >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = DMEM_data_out;
    endcase
    merged = DMEM_data_out;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wr_word_d = wr_word_q;
    rd_d      = (state_d == S_READ);
    wr_d      = (state_d == S_WRITE);
    case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          size_d  = lsu_size;
          uns_d   = lsu_unsigned;
          lane_d  = lsu_addr[1:0];
          wdata_d = lsu_wdata[15:0];
          mis_d   = req_mis;
          if (!req_mis) begin
            addr_d    = {{(32-ADDR_W){1'b0}}, lsu_addr[ADDR_W+1:2]};
            wr_word_d = lsu_wdata;
          end
        end
      end
      S_READ: begin
        if (we_q) wr_word_d = merged;
        else      rdata_d   = load_ext;
      end
      default: ;
    endcase
  end

  assign lsu_busy       = (state_q != S_IDLE);
  assign lsu_done       = (state_q == S_DONE);
  assign lsu_misalign   = (state_q == S_DONE) & mis_q;
  assign lsu_rdata      = rdata_q;
  assign DMEM_address   = addr_q;
  assign DMEM_data_in   = wr_word_q;
  assign DMEM_mem_write = wr_q;
  assign DMEM_mem_read  = rd_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized bench for lsu_dmem_ctrl against a byte-addressed memory model.
// Expected load data, write words and latencies come from plain byte arithmetic.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  logic [31:0] dmem [256];
  logic [7:0]  ref_mem [1024];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_xact = 0;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;
  logic [31:0] last_rd_addr;
  logic        r_we, r_uns;
  logic [1:0]  r_sz;
  logic [31:0] r_a;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out)
  );

  assign DMEM_data_out = dmem[DMEM_address[7:0]];

  always @(posedge clk) begin
    if (DMEM_mem_write === 1'b1) dmem[DMEM_address[7:0]] <= DMEM_data_in;
    else if (pre_en) dmem[pre_idx] <= pre_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    pre_en = 1'b1; pre_idx = idx[7:0]; pre_val = w;
    @(posedge clk); #1;
    pre_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[idx*4+k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
  endfunction

  function automatic logic [31:0] ref_load(input int b, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'h0, ref_mem[b]};
        if (!uns && ref_mem[b][7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = {16'h0, ref_mem[b+1], ref_mem[b]};
        if (!uns && ref_mem[b+1][7]) v = v | 32'hFFFF0000;
      end
      default: v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endcase
    return v;
  endfunction

  task automatic ref_store(input int b, input logic [1:0] sz, input logic [31:0] wd);
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < nbytes; k++) ref_mem[b+k] = wd[8*k +: 8];
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic        mis, got_mis;
    int          exp_done, exp_rd_cyc, exp_wr_cyc;
    int          cyc, done_cyc, rd_cyc, wr_cyc, n_rd, n_wr, widx, b;
    logic [31:0] exp_word, widx_addr;
    widx = int'(a[9:2]);
    b = int'(a[9:0]);
    widx_addr = 32'(a[9:2]);
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (mis) begin
      exp_done = 1; exp_rd_cyc = 0; exp_wr_cyc = 0;
    end else if (!we) begin
      exp_done = 2; exp_rd_cyc = 1; exp_wr_cyc = 0;
      exp_rdata = ref_load(b, sz, uns);
    end else if (sz == 2'd2) begin
      exp_done = 2; exp_rd_cyc = 0; exp_wr_cyc = 1;
    end else begin
      exp_done = 3; exp_rd_cyc = 1; exp_wr_cyc = 2;
    end
    if (we && !mis) ref_store(b, sz, wd);
    exp_word = ref_word(widx);

    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_unsigned = uns;
    lsu_addr = a; lsu_wdata = wd;
    cyc = 0; done_cyc = 0; rd_cyc = 0; wr_cyc = 0; n_rd = 0; n_wr = 0; got_mis = 1'b0;
    while (done_cyc == 0 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) lsu_req = 1'b0;
      else begin
        lsu_addr = $urandom; lsu_we = 1'($urandom_range(0, 1));
        lsu_size = 2'($urandom_range(0, 3)); lsu_wdata = $urandom;
      end
      check("rw_excl", 32'(DMEM_mem_read & DMEM_mem_write), 32'h0);
      if (DMEM_mem_read) begin
        n_rd++; rd_cyc = cyc; last_rd_addr = DMEM_address;
        check("rd_addr", DMEM_address, widx_addr);
      end
      if (DMEM_mem_write) begin
        n_wr++; wr_cyc = cyc;
        check("wr_addr", DMEM_address, widx_addr);
        check("wr_data", DMEM_data_in, exp_word);
      end
      if (lsu_done) begin
        done_cyc = cyc; got_mis = lsu_misalign; last_rdata = lsu_rdata;
        check("done_strobes", {30'h0, DMEM_mem_read, DMEM_mem_write}, 32'h0);
        if (!mis) check("done_addr_held", DMEM_address, widx_addr);
      end else begin
        check("mis_without_done", 32'(lsu_misalign), 32'h0);
        check("busy", 32'(lsu_busy), 32'h1);
      end
    end
    lsu_req = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("misalign", 32'(got_mis), 32'(mis));
    check("rdata", last_rdata, exp_rdata);
    check("read_count", 32'(n_rd), (exp_rd_cyc != 0) ? 32'h1 : 32'h0);
    check("write_count", 32'(n_wr), (exp_wr_cyc != 0) ? 32'h1 : 32'h0);
    check("read_cycle", 32'(rd_cyc), 32'(exp_rd_cyc));
    check("write_cycle", 32'(wr_cyc), 32'(exp_wr_cyc));
    @(posedge clk); #1;
    check("idle_after_done", 32'(lsu_busy), 32'h0);
    if (we && !mis) check("mem_word", dmem[widx], exp_word);
    n_xact++;
    $display("xact %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h done@%0d mis=%0d rdata=%h",
             n_xact, we, sz, uns, a, wd, done_cyc, got_mis, last_rdata);
  endtask

  initial begin
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00;
    lsu_unsigned = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    exp_rdata = 32'h0; last_rdata = 32'h0; last_rd_addr = 32'h0;
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(lsu_busy), 32'h0);
    check("rst_done", 32'(lsu_done), 32'h0);
    check("rst_misalign", 32'(lsu_misalign), 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_addr", DMEM_address, 32'h0);
    check("rst_data_in", DMEM_data_in, 32'h0);
    check("rst_write", 32'(DMEM_mem_write), 32'h0);
    check("rst_read", 32'(DMEM_mem_read), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word path
    xact(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0);
    check("sw_lit", dmem[4], 32'hDEADBEEF);
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("lw_lit", last_rdata, 32'hDEADBEEF);

    // Byte read-modify-write and extension
    preload(4, 32'h11223344);
    xact(1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h000000AB, 1'b0);
    check("sb_lit", dmem[4], 32'h11AB3344);
    xact(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
    check("lb_lit", last_rdata, 32'hFFFFFFAB);
    xact(1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, 1'b0);
    check("lbu_lit", last_rdata, 32'h000000AB);

    // Halfword
    preload(5, 32'h12345678);
    xact(1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'h00008001, 1'b0);
    check("sh_lit", dmem[5], 32'h80015678);
    xact(1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'h0, 1'b0);
    check("lh_lit", last_rdata, 32'hFFFF8001);
    xact(1'b0, 2'd1, 1'b1, 32'h0000_0016, 32'h0, 1'b0);
    check("lhu_lit", last_rdata, 32'h00008001);

    // Misalignment: no memory activity, rdata held
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0021, 32'h0, 1'b0);
    xact(1'b1, 2'd1, 1'b0, 32'h0000_0023, 32'h0000FFFF, 1'b0);
    xact(1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    check("mis_rdata_lit", last_rdata, 32'h00008001);

    // Request held with changing inputs while busy, then aliasing
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0, 1'b1);
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0410, 32'h0, 1'b0);
    check("alias_addr", last_rd_addr, 32'h4);

    // Random traffic, mostly aligned
    for (int t = 0; t < 200; t++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'd1) r_a[0] = 1'b0;
        if (r_sz == 2'd2) r_a[1:0] = 2'b00;
      end
      r_we = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      xact(r_we, r_sz, r_uns, r_a, $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset during the write cycle of a byte store
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd0; lsu_unsigned = 1'b0;
    lsu_addr = 32'h0000_0031; lsu_wdata = 32'h0000005A;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_write", 32'(DMEM_mem_write), 32'h1);
    rst_n = 1'b0;
    ref_store(32'h31, 2'd0, 32'h5A);
    @(posedge clk); #1;
    check("rstw_write", 32'(DMEM_mem_write), 32'h0);
    check("rstw_read", 32'(DMEM_mem_read), 32'h0);
    check("rstw_busy", 32'(lsu_busy), 32'h0);
    check("rstw_done", 32'(lsu_done), 32'h0);
    check("rstw_rdata", lsu_rdata, 32'h0);
    check("rstw_addr", DMEM_address, 32'h0);
    check("rstw_data_in", DMEM_data_in, 32'h0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rstw_quiet", {29'h0, DMEM_mem_read, DMEM_mem_write, lsu_busy}, 32'h0);
    end
    check("rstw_mem", dmem[12], ref_word(12));
    $display("xact %0d reset during byte store write at 00000031: outputs cleared", n_xact + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

- Load/store controller: the initiator side of the data-memory port.
- Sits between the CPU execute/memory stage and the word-indexed, combinationally-read DMEM.
- Accepts one byte, halfword or word request at a time and translates the byte address to a DMEM word index.
- Performs read-modify-write for sub-word stores, sign/zero-extends sub-word loads, and flags misaligned accesses without touching memory.

## Interface

Parameters:
- ADDR_W, 8, DMEM word-index width; byte addresses span 2^(ADDR_W+2) bytes.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- lsu_req  in  1  request strobe; sampled only in IDLE
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as misaligned
- lsu_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- lsu_busy  out  1  high whenever state ≠ IDLE
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  extended load result; held until the next load completes
- lsu_misalign  out  1  valid with lsu_done; 1 = request rejected
- DMEM_address  out  32  {zeros, lsu_addr[ADDR_W+1:2]}, registered
- DMEM_data_in  out  32  registered write word
- DMEM_mem_write  out  1  registered write enable
- DMEM_mem_read  out  1  registered read enable
- DMEM_data_out  in  32  combinational read data from DMEM

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE with lsu_req=1: latch we, size, unsigned, addr and wdata, then pick the path:
  - Misaligned (size 11; half with addr[0]=1; word with addr[1:0]≠00): go to DONE with misalign=1. No DMEM strobe is ever raised.
  - Load of any size: READ → DONE.
  - Word store: WRITE → DONE.
  - Byte or half store: READ → WRITE → DONE.
- READ:
  - DMEM_mem_read=1 and DMEM_address = word index.
  - At the end of the cycle, capture DMEM_data_out into the word buffer.
- Sub-word store merge (little-endian, lane = addr[1:0]):
  - Byte: replace buffer bits [8*lane+7 : 8*lane] with wdata[7:0].
  - Half: replace [16*addr[1]+15 : 16*addr[1]] with wdata[15:0].
  - Merged word goes to DMEM_data_in.
- WRITE:
  - DMEM_mem_write=1; DMEM_address and DMEM_data_in are stable for the whole cycle.
  - Word store writes wdata unmodified.
- DONE:
  - lsu_done=1; both DMEM strobes 0; DMEM_address is held (DMEM write is level-sensitive, so the address must not move while mem_write falls).
  - Loads: select the lane, extend per lsu_unsigned, register into lsu_rdata. For word loads lsu_unsigned is ignored.
  - Always return to IDLE next.
- lsu_req is ignored while busy. Request inputs are not re-sampled after acceptance.
- Byte-address bits above ADDR_W+1 are ignored (aliasing); this is not an error.
- Reset (any state, including mid-WRITE): next edge state=IDLE and every output is 0 (lsu_rdata=0, DMEM_address=0). An in-flight sub-word store is abandoned: either no DMEM write occurs, or a complete single-cycle write has already occurred.

## Timing

- Request in cycle 0 (IDLE). lsu_done appears in:
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Misaligned: cycle 1.
- Earliest next acceptance: the cycle after DONE.
  - Back-to-back word loads: one every 3 cycles.
- DMEM_mem_read and DMEM_mem_write are never high in the same cycle.
- Each strobe is high for exactly one cycle per access.
- lsu_misalign equals 0 whenever lsu_done=0.

## Test plan

- Reset:
  - Hold rst_n=0 for 2 cycles → all outputs 0, busy=0.
  - Assert rst_n=0 during the WRITE of a byte store → next cycle state IDLE, mem_write=0, no further DMEM activity.
- Word path:
  - Store word 0xDEADBEEF at 0x0000_0010 → DMEM_address=4 with mem_write for one cycle in cycle 1, done in cycle 2.
  - Load word from the same address → lsu_rdata=0xDEADBEEF in cycle 2.
- Byte RMW and extension:
  - Preload word 4 = 0x11223344, store byte 0xAB to 0x12 → DMEM word 4 becomes 0x11AB3344, done in cycle 3.
  - Signed byte load from 0x12 → 0xFFFFFFAB.
  - Unsigned byte load from 0x12 → 0x000000AB.
- Halfword:
  - Store half 0x8001 to 0x16 → word 5 upper half = 0x8001, lower half unchanged.
  - Signed half load → 0xFFFF8001; unsigned → 0x00008001.
- Misalignment:
  - Word load at 0x21 → done and misalign=1 in cycle 1, no DMEM strobe, lsu_rdata unchanged.
  - Half store at 0x23 → same response.
  - size=11 → same response.
- Busy and aliasing:
  - Hold lsu_req=1 with changing lsu_addr during a load → only the first request is serviced.
  - Load from 0x0000_0410 with ADDR_W=8 → DMEM_address=4.
